wb_cmd_master: RTL
==================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum wait cycles for wb_ack_i per bus access before abort.
REQ-002 Parameter POLL_MAX, default 255: maximum read attempts for one poll command.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 nRST  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-007 cmd_we  input  1  1 = write, 0 = read; ignored when cmd_poll=1.
REQ-008 cmd_poll  input  1  1 = repeat reads until a masked match.
REQ-009 cmd_adr  input  32  bus address.
REQ-010 cmd_dat  input  32  write data, or poll compare value.
REQ-011 cmd_mask  input  32  poll compare mask.
REQ-012 cmd_sel  input  4  byte selects.
REQ-013 rsp_valid  output  1  one-cycle response strobe.
REQ-014 rsp_dat  output  32  last read data; 0 for writes and timeouts.
REQ-015 rsp_err  output  1  ack timeout occurred.
REQ-016 rsp_poll_fail  output  1  poll attempts exhausted without a match.
REQ-017 wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o  output  32/32/4/1/1/1  Wishbone classic master signals, all registered.
REQ-018 wb_ack_i  input  1; wb_dat_i  input  32  slave acknowledge and read data.

Function
REQ-019 FSM states SHALL be IDLE, BUS, GAP, RESP.
REQ-020 cmd_ready SHALL be 1 only in IDLE; the command fields SHALL be latched on acceptance.
REQ-021 On the acceptance edge the state SHALL move to BUS, and wb_cyc_o=wb_stb_o=1 SHALL be driven from the next cycle.
REQ-022 wb_we_o SHALL equal cmd_we & ~cmd_poll; wb_dat_o SHALL be cmd_dat for writes and 0 for reads.
REQ-023 In BUS, all wb_*_o outputs SHALL hold stable until ack or timeout.
REQ-024 A wait counter SHALL clear on entry to BUS and increment each BUS cycle without ack.
REQ-025 When wb_ack_i=1 in cycle k: read data SHALL be captured, and wb_cyc_o/wb_stb_o SHALL be 0 in cycle k+1.
REQ-026 After ack, writes and non-poll reads SHALL go to RESP, so rsp_valid is high in cycle k+1.
REQ-027 Poll match condition: (wb_dat_i & cmd_mask) == (cmd_dat & cmd_mask).
REQ-028 On a poll match, the state SHALL go to RESP.
REQ-029 On a poll mismatch with attempt count < POLL_MAX, the state SHALL go to GAP: one cycle with cyc/stb low, then BUS again with the same address.
REQ-030 On a poll mismatch at attempt POLL_MAX, the state SHALL go to RESP with rsp_poll_fail=1 and rsp_dat set to the last read data.
REQ-031 When the wait counter reaches TIMEOUT_CYCLES without ack: cyc/stb SHALL drop the next cycle, and RESP SHALL carry rsp_err=1 and rsp_dat=0.
REQ-032 If ack and timeout fall in the same cycle, ack SHALL win.
REQ-033 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; cmd_ready SHALL be high in cycle k+2.
REQ-034 Outside RESP, rsp_valid SHALL be 0; rsp_dat, rsp_err and rsp_poll_fail SHALL hold their last values.
REQ-035 The attempt counter SHALL saturate at POLL_MAX and never wrap.
REQ-036 wb_ack_i seen outside BUS SHALL be ignored.

Reset
REQ-037 With nRST=0 at a rising edge: state=IDLE; all wb_*_o=0; rsp_valid=rsp_err=rsp_poll_fail=0; rsp_dat=0; counters=0.
REQ-038 Reset during BUS or GAP SHALL abort the access: cyc/stb are 0 the next cycle, and no response is issued.
REQ-039 cmd_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-040 Write scenario: cmd adr=0x00000008, dat=0x0C0D0E0F, sel=0xF, slave acks after 2 wait cycles. Required: wb_*_o stable for 3 cycles, wb_we_o=1, one rsp_valid pulse, rsp_err=0, rsp_dat=0.
REQ-041 Read scenario: adr=0x00000004, zero-wait ack with wb_dat_i=0xDEADBEEF. Required: cyc high exactly 1 cycle, rsp_valid in the next cycle, rsp_dat=0xDEADBEEF.
REQ-042 Timeout scenario: read with no ack, TIMEOUT_CYCLES=16. Required: cyc high 16 cycles then 0, rsp_err=1, rsp_dat=0, cmd_ready back 1 cycle later.
REQ-043 Poll match scenario: adr=0x00000000, mask=0x1, value=0x1; slave returns 0x0, 0x0, 0x1. Required: 3 bus accesses each separated by a 1-cycle cyc-low gap, rsp_dat=0x1, rsp_poll_fail=0.
REQ-044 Poll fail scenario: POLL_MAX=4 and the slave always returns 0x0. Required: exactly 4 accesses, rsp_poll_fail=1.
REQ-045 Reset and simultaneity scenario: assert nRST=0 in the 2nd BUS cycle. Required: cyc=0 next cycle, no rsp_valid. Then ack coinciding with the timeout cycle. Required: rsp_err=0 and data captured.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Command-driven Wishbone classic master: single read/write accesses or masked
// polling reads, with per-access ack timeout and a one-cycle response strobe.
module wb_cmd_master #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int POLL_MAX       = 255
) (
   input  logic        clk,
   input  logic        nRST,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic        cmd_poll,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   input  logic [31:0] cmd_mask,
   input  logic [3:0]  cmd_sel,
   output logic        rsp_valid,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic        rsp_poll_fail,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   input  logic [31:0] wb_dat_i
);

   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int ATT_W  = $clog2(POLL_MAX + 1);

   typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [ATT_W-1:0]  att_q, att_d;
   logic              poll_q, poll_d;
   logic [31:0]       cmp_q, cmp_d;
   logic [31:0]       mask_q, mask_d;
   logic [31:0]       adr_q, adr_d;
   logic [31:0]       dat_q, dat_d;
   logic [3:0]        sel_q, sel_d;
   logic              we_q, we_d;
   logic              cyc_q, cyc_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_dat_q, rsp_dat_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_poll_fail_q, rsp_poll_fail_d;
   logic              poll_match;
   logic              att_last;
   logic              wait_last;

   assign poll_match = ((wb_dat_i ^ cmp_q) & mask_q) == 32'h0;
   // att_q counts completed attempts, so the current access is number att_q+1
   assign att_last   = att_q >= ATT_W'(POLL_MAX - 1);
   assign wait_last  = wait_q == WAIT_W'(TIMEOUT_CYCLES - 1);

   always_comb begin
      state_d         = state_q;
      wait_d          = wait_q;
      att_d           = att_q;
      poll_d          = poll_q;
      cmp_d           = cmp_q;
      mask_d          = mask_q;
      adr_d           = adr_q;
      dat_d           = dat_q;
      sel_d           = sel_q;
      we_d            = we_q;
      cyc_d           = cyc_q;
      rsp_valid_d     = 1'b0;
      rsp_dat_d       = rsp_dat_q;
      rsp_err_d       = rsp_err_q;
      rsp_poll_fail_d = rsp_poll_fail_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               adr_d   = cmd_adr;
               sel_d   = cmd_sel;
               we_d    = cmd_we & ~cmd_poll;
               dat_d   = (cmd_we & ~cmd_poll) ? cmd_dat : 32'h0;
               poll_d  = cmd_poll;
               cmp_d   = cmd_dat;
               mask_d  = cmd_mask;
               cyc_d   = 1'b1;
               wait_d  = '0;
               att_d   = '0;
               state_d = BUS;
            end
         end
         BUS: begin
            // ack is checked before the timeout so it wins a same-cycle tie
            if (wb_ack_i) begin
               cyc_d = 1'b0;
               if (poll_q && att_q != ATT_W'(POLL_MAX)) begin
                  att_d = att_q + 1'b1;
               end
               if (poll_q && !poll_match && !att_last) begin
                  state_d = GAP;
               end else begin
                  state_d         = RESP;
                  rsp_valid_d     = 1'b1;
                  rsp_err_d       = 1'b0;
                  rsp_poll_fail_d = poll_q & ~poll_match;
                  rsp_dat_d       = we_q ? 32'h0 : wb_dat_i;
               end
            end else begin
               wait_d = wait_q + 1'b1;
               if (wait_last) begin
                  cyc_d           = 1'b0;
                  state_d         = RESP;
                  rsp_valid_d     = 1'b1;
                  rsp_err_d       = 1'b1;
                  rsp_poll_fail_d = 1'b0;
                  rsp_dat_d       = 32'h0;
               end
            end
         end
         GAP: begin
            cyc_d   = 1'b1;
            wait_d  = '0;
            state_d = BUS;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nRST) begin
         state_q         <= IDLE;
         wait_q          <= '0;
         att_q           <= '0;
         poll_q          <= 1'b0;
         adr_q           <= 32'h0;
         dat_q           <= 32'h0;
         sel_q           <= 4'h0;
         we_q            <= 1'b0;
         cyc_q           <= 1'b0;
         rsp_valid_q     <= 1'b0;
         rsp_dat_q       <= 32'h0;
         rsp_err_q       <= 1'b0;
         rsp_poll_fail_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         wait_q          <= wait_d;
         att_q           <= att_d;
         poll_q          <= poll_d;
         adr_q           <= adr_d;
         dat_q           <= dat_d;
         sel_q           <= sel_d;
         we_q            <= we_d;
         cyc_q           <= cyc_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_dat_q       <= rsp_dat_d;
         rsp_err_q       <= rsp_err_d;
         rsp_poll_fail_q <= rsp_poll_fail_d;
      end
   end

   // Poll compare operands only matter while a command is in flight
   always_ff @(posedge clk) begin
      cmp_q  <= cmp_d;
      mask_q <= mask_d;
   end

   assign cmd_ready     = (state_q == IDLE);
   assign wb_adr_o      = adr_q;
   assign wb_dat_o      = dat_q;
   assign wb_sel_o      = sel_q;
   assign wb_we_o       = we_q;
   assign wb_cyc_o      = cyc_q;
   assign wb_stb_o      = cyc_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_dat       = rsp_dat_q;
   assign rsp_err       = rsp_err_q;
   assign rsp_poll_fail = rsp_poll_fail_q;

endmodule
